// File: rtl/pkt_pkg.sv
// Shared packet definitions used by the builder and the parser.
package pkt_pkg;

    localparam int unsigned HDR_BYTES = 8;
    localparam int unsigned WORD_W    = 32;

    typedef enum logic [1:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StPayload
    } pkt_state_e;

    // Header fields travel little-endian inside an MSB-first beat.
    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/seq_table.sv
// Per-stream 32-bit sequence counters, indexed by the low stream-id bits.
module seq_table
    import pkt_pkg::*;
#(
    parameter int unsigned STREAM_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic [STREAM_BITS-1:0] idx,
    input  logic                   inc,
    output logic [WORD_W-1:0]      seq
);

    localparam int unsigned Entries = 1 << STREAM_BITS;

    logic [WORD_W-1:0] cnt_q [Entries];

    // Counter array; the selected entry wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < Entries; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc) begin
            cnt_q[idx] <= cnt_q[idx] + 32'd1;
        end
    end

    assign seq = cnt_q[idx];

endmodule

// File: rtl/packet_builder.sv
// Serialises one message into header + payload beats with a per-stream sequence stamp.
module packet_builder
    import pkt_pkg::*;
#(
    parameter int unsigned STREAM_BITS = 4,
    parameter int unsigned MAX_PAYLOAD = 32
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [0:MAX_PAYLOAD*8-1] msgIn_data,
    input  logic [15:0]              msgIn_stream,
    input  logic [15:0]              msgIn_len,
    input  logic                     msgIn_val,
    output logic                     msgIn_ready,
    output logic                     msgIn_err,
    output logic [31:0]              dataOut,
    output logic                     dataOut_val,
    input  logic                     dataOut_ready,
    output logic                     dataOut_last
);

    localparam int unsigned BeatW = (MAX_PAYLOAD > 4) ? $clog2((MAX_PAYLOAD + 3) / 4) : 1;
    localparam int unsigned IdxW  = BeatW + 2;

    pkt_state_e               state_q, state_d;
    logic [0:MAX_PAYLOAD*8-1] data_q;
    logic [15:0]              len_q;
    logic [15:0]              stream_q;
    logic [BeatW-1:0]         beat_q;
    logic [BeatW-1:0]         last_beat_q;
    logic                     err_q;

    logic [WORD_W-1:0]        seq;
    logic                     accept;
    logic                     legal;
    logic                     beat_hs;
    logic                     seq_inc;
    logic [IdxW-1:0]          len_m1;
    logic [15:0]              pkt_len;
    logic [IdxW-1:0]          byte_idx;

    assign accept      = msgIn_val & msgIn_ready;
    assign legal       = (msgIn_len != 16'd0) && (msgIn_len <= 16'(MAX_PAYLOAD));
    assign msgIn_ready = (state_q == StIdle);
    assign msgIn_err   = err_q;
    assign beat_hs     = dataOut_val & dataOut_ready;
    assign seq_inc     = (state_q == StPayload) & beat_hs & dataOut_last;
    // Only meaningful for legal lengths, where len-1 always fits in IdxW bits.
    assign len_m1      = IdxW'(msgIn_len - 16'd1);
    assign pkt_len     = len_q + 16'(HDR_BYTES);

    seq_table #(
        .STREAM_BITS(STREAM_BITS)
    ) u_seq_table (
        .clk    (clk),
        .reset_b(reset_b),
        .idx    (stream_q[STREAM_BITS-1:0]),
        .inc    (seq_inc),
        .seq    (seq)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: illegal messages are swallowed without leaving idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept && legal) state_d = StHdr0;
            StHdr0:    if (beat_hs) state_d = StHdr1;
            StHdr1:    if (beat_hs) state_d = StPayload;
            StPayload: if (beat_hs && dataOut_last) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Message capture, payload beat counter and error pulse.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            data_q      <= '0;
            len_q       <= '0;
            stream_q    <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept & ~legal;
            if (accept && legal) begin
                data_q      <= msgIn_data;
                len_q       <= msgIn_len;
                stream_q    <= msgIn_stream;
                beat_q      <= '0;
                last_beat_q <= len_m1[IdxW-1:2];
            end else if (state_q == StPayload && beat_hs) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // Beat formatting; outputs derive only from registers so reset clears them at once.
    always_comb begin
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        byte_idx     = '0;
        unique case (state_q)
            StHdr0: begin
                dataOut_val = 1'b1;
                dataOut     = {swap16(pkt_len), swap16(stream_q)};
            end
            StHdr1: begin
                dataOut_val = 1'b1;
                dataOut     = swap32(seq);
            end
            StPayload: begin
                dataOut_val  = 1'b1;
                dataOut_last = (beat_q == last_beat_q);
                for (int k = 0; k < 4; k++) begin
                    byte_idx = {beat_q, 2'(k)};
                    if (16'(byte_idx) < len_q) begin
                        dataOut[31-8*k -: 8] = data_q[8*byte_idx +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder: header/payload formatting, sequencing, stalls, errors, reset.
module tb_packet_builder;

    logic          clk;
    logic          reset_b;
    logic [0:255]  msgIn_data;
    logic [15:0]   msgIn_stream;
    logic [15:0]   msgIn_len;
    logic          msgIn_val;
    logic          msgIn_ready;
    logic          msgIn_err;
    logic [31:0]   dataOut;
    logic          dataOut_val;
    logic          dataOut_ready;
    logic          dataOut_last;

    int            total = 0;
    int            bad = 0;
    logic          rand_mode = 1'b0;
    logic [31:0]   exp_seq [16];
    logic [31:0]   exp_beats [$];
    logic [31:0]   got_beats [$];
    logic          got_last [$];
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_beat = '0;
    logic          prev_last = 1'b0;

    packet_builder #(
        .STREAM_BITS(4),
        .MAX_PAYLOAD(32)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .msgIn_data   (msgIn_data),
        .msgIn_stream (msgIn_stream),
        .msgIn_len    (msgIn_len),
        .msgIn_val    (msgIn_val),
        .msgIn_ready  (msgIn_ready),
        .msgIn_err    (msgIn_err),
        .dataOut      (dataOut),
        .dataOut_val  (dataOut_val),
        .dataOut_ready(dataOut_ready),
        .dataOut_last (dataOut_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Downstream ready, optionally randomised.
    initial begin
        dataOut_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dataOut_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Beat collector plus stall-stability and busy checks.
    always @(negedge clk) begin
        if (reset_b) begin
            if (prev_stall) begin
                check("hold_val", {31'd0, dataOut_val}, 32'd1);
                check("hold_beat", dataOut, prev_beat);
                check("hold_last", {31'd0, dataOut_last}, {31'd0, prev_last});
            end
            if (dataOut_val) check("busy_ready", {31'd0, msgIn_ready}, 32'd0);
            if (dataOut_val && dataOut_ready) begin
                got_beats.push_back(dataOut);
                got_last.push_back(dataOut_last);
            end
            prev_stall = dataOut_val && !dataOut_ready;
            prev_beat  = dataOut;
            prev_last  = dataOut_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [15:0] s, input logic [15:0] len, input logic [7:0] base);
        int n = 0;
        @(negedge clk);
        msgIn_stream = s;
        msgIn_len    = len;
        // Fill all 32 bytes so padding of the final beat is exercised.
        for (int k = 0; k < 32; k++) msgIn_data[8*k +: 8] = 8'(base + 8'(k));
        msgIn_val = 1'b1;
        while (!msgIn_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!msgIn_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        msgIn_val = 1'b0;
    endtask

    task automatic build_exp(input logic [15:0] s, input logic [15:0] len, input logic [7:0] base,
                             input logic [31:0] q);
        logic [15:0] l;
        logic [31:0] word;
        int          nb;
        int          idx;
        exp_beats.delete();
        l = len + 16'd8;
        exp_beats.push_back({l[7:0], l[15:8], s[7:0], s[15:8]});
        exp_beats.push_back({q[7:0], q[15:8], q[23:16], q[31:24]});
        nb = (int'(len) + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
                idx = 4 * b + k;
                if (idx < int'(len)) word[31-8*k -: 8] = 8'(base + 8'(idx));
            end
            exp_beats.push_back(word);
        end
    endtask

    task automatic run_pkt(input logic [15:0] s, input logic [15:0] len, input logic [7:0] base);
        int n = 0;
        build_exp(s, len, base, exp_seq[s[3:0]]);
        got_beats.delete();
        got_last.delete();
        send(s, len, base);
        while (got_beats.size() < exp_beats.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check($sformatf("beat_count s%0d l%0d", s, len), got_beats.size(), exp_beats.size());
        for (int i = 0; i < exp_beats.size(); i++) begin
            if (i < got_beats.size()) begin
                check($sformatf("beat s%0d l%0d #%0d", s, len, i), got_beats[i], exp_beats[i]);
                check($sformatf("last s%0d l%0d #%0d", s, len, i), {31'd0, got_last[i]},
                      (i == exp_beats.size() - 1) ? 32'd1 : 32'd0);
            end
        end
        exp_seq[s[3:0]] = exp_seq[s[3:0]] + 32'd1;
    endtask

    task automatic bad_len(input logic [15:0] len);
        got_beats.delete();
        send(16'd12, len, 8'h77);
        @(negedge clk);
        check($sformatf("err_pulse l%0d", len), {31'd0, msgIn_err}, 32'd1);
        check($sformatf("err_noval l%0d", len), {31'd0, dataOut_val}, 32'd0);
        @(negedge clk);
        check($sformatf("err_clear l%0d", len), {31'd0, msgIn_err}, 32'd0);
        check($sformatf("err_idle l%0d", len), {31'd0, msgIn_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check($sformatf("err_nobeats l%0d", len), got_beats.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) exp_seq[i] = '0;
        reset_b      = 1'b0;
        msgIn_data   = '0;
        msgIn_stream = '0;
        msgIn_len    = '0;
        msgIn_val    = 1'b0;
        #2;
        check("rst_ready", {31'd0, msgIn_ready}, 32'd1);
        check("rst_err", {31'd0, msgIn_err}, 32'd0);
        check("rst_data", dataOut, 32'd0);
        check("rst_val", {31'd0, dataOut_val}, 32'd0);
        check("rst_last", {31'd0, dataOut_last}, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // Test-plan packets with hand-computed beats.
        run_pkt(16'd12, 16'd12, 8'h01);
        check("p1_b0", got_beats[0], 32'h14000C00);
        check("p1_b1", got_beats[1], 32'h00000000);
        check("p1_b2", got_beats[2], 32'h01020304);
        check("p1_b3", got_beats[3], 32'h05060708);
        check("p1_b4", got_beats[4], 32'h090A0B0C);
        run_pkt(16'd12, 16'd13, 8'h01);
        check("p2_n", got_beats.size(), 32'd6);
        check("p2_b0", got_beats[0], 32'h15000C00);
        check("p2_b1", got_beats[1], 32'h01000000);
        check("p2_b5", got_beats[5], 32'h0D000000);

        // Interleaved streams and an aliasing stream id.
        run_pkt(16'd14, 16'd8, 8'h20);
        run_pkt(16'd12, 16'd4, 8'h30);
        check("seq_s12", got_beats[1], 32'h02000000);
        run_pkt(16'd28, 16'd1, 8'h40);
        check("seq_alias28", got_beats[1], 32'h03000000);
        run_pkt(16'd14, 16'd5, 8'h50);
        check("seq_s14", got_beats[1], 32'h01000000);

        // Random backpressure.
        rand_mode = 1'b1;
        run_pkt(16'h0103, 16'd32, 8'hA0);
        run_pkt(16'd12, 16'd17, 8'h10);
        run_pkt(16'd7, 16'd3, 8'hF0);
        run_pkt(16'd12, 16'd9, 8'h60);
        rand_mode = 1'b0;

        // Illegal lengths leave the sequence untouched.
        bad_len(16'd0);
        bad_len(16'd33);
        run_pkt(16'd12, 16'd2, 8'h90);
        check("seq_after_err", got_beats[1], 32'h06000000);

        // Reset in the middle of a payload.
        got_beats.delete();
        send(16'd12, 16'd20, 8'h40);
        repeat (3) @(negedge clk);
        check("pre_rst_val", {31'd0, dataOut_val}, 32'd1);
        #1;
        reset_b = 1'b0;
        #1;
        check("mid_rst_val", {31'd0, dataOut_val}, 32'd0);
        check("mid_rst_data", dataOut, 32'd0);
        check("mid_rst_last", {31'd0, dataOut_last}, 32'd0);
        check("mid_rst_ready", {31'd0, msgIn_ready}, 32'd1);
        @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 16; i++) exp_seq[i] = '0;
        repeat (2) @(negedge clk);
        run_pkt(16'd12, 16'd12, 8'h01);
        check("post_rst_seq", got_beats[1], 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
